// File: rtl/conv_window5x5_gen_if.sv
`default_nettype none
// ============================================================================
// conv_window5x5_gen_if : pixel stream in, 5x5 window stream out (WIN_POS_OUT_EN adds window position)
// Revision 1.0
// ============================================================================
interface conv_window5x5_gen_if #(
   parameter int DATA_W = 8
`ifdef WIN_POS_OUT_EN
   ,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
`endif
);
   logic                   valid_in;
   logic [DATA_W-1:0]      pix_in;
   logic                   valid_out;
   logic [25*DATA_W-1:0]   win;
   logic                   frame_done;
`ifdef WIN_POS_OUT_EN
   logic [$clog2(IMG_H)-1:0] out_row;
   logic [$clog2(IMG_W)-1:0] out_col;
`endif

   modport master (
      output valid_in,
      output pix_in,
      input  valid_out,
      input  win,
      input  frame_done
`ifdef WIN_POS_OUT_EN
      ,
      input  out_row,
      input  out_col
`endif
   );

   modport slave (
      input  valid_in,
      input  pix_in,
      output valid_out,
      output win,
      output frame_done
`ifdef WIN_POS_OUT_EN
      ,
      output out_row,
      output out_col
`endif
   );
endinterface
`default_nettype wire

// File: rtl/conv_window5x5_gen.sv
`default_nettype none
// ============================================================================
// conv_window5x5_gen : streaming 5x5 sliding-window generator, 4 line buffers.
// Optional macro WIN_POS_OUT_EN adds out_row/out_col (window top-left).
// Revision 1.0
// ============================================================================
module conv_window5x5_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   conv_window5x5_gen_if.slave  bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_FOUR = COL_W'(4);
   localparam logic [ROW_W-1:0] ROW_FOUR = ROW_W'(4);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [COL_W-1:0]    col;
   logic [COL_W-1:0]    col_nxt;
   logic [ROW_W-1:0]    row;
   logic [ROW_W-1:0]    row_nxt;
   logic                accept;
   logic                win_ok;
   logic                last_pix;

   logic [DATA_W-1:0]   lb [4][IMG_W];
   logic [DATA_W-1:0]   new_col [5];
   logic [DATA_W-1:0]   tap [5][5];
   logic [25*DATA_W-1:0] tap_flat;

   logic                stage_acc;
   logic                stage_vld;
   logic                stage_last;
   logic                valid_q;
   logic                done_q;
   logic [25*DATA_W-1:0] win_q;

   // Counter advance and state derivation; S_RUN mirrors row >= 4.
   always_comb begin
      accept   = bus.valid_in;
      col_nxt  = col;
      row_nxt  = row;
      last_pix = (col == COL_LAST) && (row == ROW_LAST);
      if (accept) begin
         if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
         end else begin
            col_nxt = col + COL_W'(1);
         end
      end
      state_nxt = (row_nxt >= ROW_FOUR) ? S_RUN : S_FILL;
      win_ok    = accept && (state == S_RUN) && (col >= COL_FOUR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FILL;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   // Column entering the window: lb[3] holds the oldest row, pix_in the newest.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         new_col[r] = lb[3-r][col];
      end
      new_col[4] = bus.pix_in;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb[0][col] <= bus.pix_in;
         for (int i = 1; i < 4; i++) begin
            lb[i][col] <= lb[i-1][col];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               tap[r][c] <= '0;
            end
         end
         stage_acc  <= 1'b0;
         stage_vld  <= 1'b0;
         stage_last <= 1'b0;
      end else begin
         stage_acc  <= accept;
         stage_vld  <= win_ok;
         stage_last <= win_ok && last_pix;
         if (accept) begin
            for (int r = 0; r < 5; r++) begin
               for (int c = 0; c < 4; c++) begin
                  tap[r][c] <= tap[r][c+1];
               end
               tap[r][4] <= new_col[r];
            end
         end
      end
   end

   for (genvar r = 0; r < 5; r++) begin : g_row
      for (genvar c = 0; c < 5; c++) begin : g_col
         assign tap_flat[(r*5+c)*DATA_W +: DATA_W] = tap[r][c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         win_q   <= '0;
      end else begin
         valid_q <= stage_vld;
         done_q  <= stage_last;
         if (stage_acc) begin
            win_q <= tap_flat;
         end
      end
   end

   assign bus.valid_out  = valid_q;
   assign bus.frame_done = done_q;
   assign bus.win        = win_q;

`ifdef WIN_POS_OUT_EN
   logic [ROW_W-1:0] stage_row;
   logic [COL_W-1:0] stage_col;
   logic [ROW_W-1:0] pos_row_q;
   logic [COL_W-1:0] pos_col_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_row <= '0;
         stage_col <= '0;
         pos_row_q <= '0;
         pos_col_q <= '0;
      end else begin
         if (win_ok) begin
            stage_row <= row - ROW_FOUR;
            stage_col <= col - COL_FOUR;
         end
         if (stage_vld) begin
            pos_row_q <= stage_row;
            pos_col_q <= stage_col;
         end
      end
   end

   assign bus.out_row = pos_row_q;
   assign bus.out_col = pos_col_q;
`else
`endif
endmodule
`default_nettype wire

// File: tb/tb_conv_window5x5_gen.sv
`default_nettype none
// ============================================================================
// tb_conv_window5x5_gen : random-stimulus bench, windows predicted from a stored image
// Revision 1.0
// ============================================================================
module tb_conv_window5x5_gen;
   localparam int DATA_W        = 8;
   localparam int IMG_W         = 32;
   localparam int IMG_H         = 32;
   localparam int WIN_PER_FRAME = (IMG_W - 4) * (IMG_H - 4);
   localparam int TW            = 25 * DATA_W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

`ifdef WIN_POS_OUT_EN
   conv_window5x5_gen_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();
`else
   conv_window5x5_gen_if #(.DATA_W(DATA_W)) bus ();
`endif

   conv_window5x5_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      int            due;
      logic [TW-1:0] win;
      logic          last;
      int            r;
      int            c;
      logic          pat0;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] img [IMG_H][IMG_W];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_bad = 0;
   int                n_vout = 0;
   int                n_done = 0;
   logic              mon_exp_v;
   exp_t              mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Called at a falling edge; the beat is taken at the next rising edge.
   task automatic beat(input int r, input int c, input logic [DATA_W-1:0] pix, input logic pat0);
      exp_t e;
      bus.valid_in = 1'b1;
      bus.pix_in   = pix;
      img[r][c]    = pix;
      if (r >= 4 && c >= 4) begin
         for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
               e.win[(rr*5+cc)*DATA_W +: DATA_W] = img[r-4+rr][c-4+cc];
         e.due  = cyc + 2;
         e.last = (r == IMG_H-1) && (c == IMG_W-1);
         e.r    = r;
         e.c    = c;
         e.pat0 = pat0;
         exp_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      bus.valid_in = 1'b0;
      bus.pix_in   = DATA_W'($urandom);
      @(negedge clk);
   endtask

   function automatic logic [DATA_W-1:0] pat_pix(input int r, input int c);
      return DATA_W'((r * IMG_W + c) & 8'hFF);
   endfunction

   task automatic send_frame(input int gap_pct, input logic pat0);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) begin
            while (int'($urandom_range(99)) < gap_pct) idle();
            beat(r, c, pat0 ? pat_pix(r, c) : DATA_W'($urandom), pat0);
         end
   endtask

   task automatic drain();
      int k = 0;
      bus.valid_in = 1'b0;
      while (exp_q.size() > 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("drain_pending", 256'(exp_q.size()), 256'(0));
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_pulse();
      #2;
      rst_n        = 1'b0;
      bus.valid_in = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_valid_out", 256'(bus.valid_out), 256'(0));
         check("rst_frame_done", 256'(bus.frame_done), 256'(0));
         check("rst_win", 256'(bus.win), 256'(0));
      end else begin
         mon_exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("valid_out", 256'(bus.valid_out), 256'(mon_exp_v));
         if (bus.valid_out) n_vout++;
         if (bus.frame_done) n_done++;
         if (mon_exp_v) begin
            mon_e = exp_q.pop_front();
            check("win", 256'(bus.win), 256'(mon_e.win));
            check("frame_done", 256'(bus.frame_done), 256'(mon_e.last));
`ifdef WIN_POS_OUT_EN
            check("out_row", 256'(bus.out_row), 256'(mon_e.r - 4));
            check("out_col", 256'(bus.out_col), 256'(mon_e.c - 4));
`endif
            if (mon_e.pat0 && mon_e.r == 4 && mon_e.c == 4) begin
               check("first_tap0", 256'(bus.win[0*DATA_W +: DATA_W]), 256'(0));
               check("first_tap4", 256'(bus.win[4*DATA_W +: DATA_W]), 256'(4));
               check("first_tap20", 256'(bus.win[20*DATA_W +: DATA_W]), 256'(128));
               check("first_tap24", 256'(bus.win[24*DATA_W +: DATA_W]), 256'(132));
            end
            if (mon_e.pat0 && mon_e.r == IMG_H-1 && mon_e.c == IMG_W-1)
               check("last_tap24", 256'(bus.win[24*DATA_W +: DATA_W]), 256'(8'hFF));
         end else begin
            check("frame_done_idle", 256'(bus.frame_done), 256'(0));
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      bus.valid_in = 1'b0;
      bus.pix_in   = '0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      // Gap-free ramp frame
      n_vout = 0; n_done = 0;
      send_frame(0, 1'b1);
      drain();
      check("t1_windows", 256'(n_vout), 256'(WIN_PER_FRAME));
      check("t1_frame_done", 256'(n_done), 256'(1));

      // Same frame with ~50% input gaps
      n_vout = 0; n_done = 0;
      send_frame(50, 1'b1);
      drain();
      check("t2_windows", 256'(n_vout), 256'(WIN_PER_FRAME));
      check("t2_frame_done", 256'(n_done), 256'(1));

      // Random frame immediately followed by ramp frame
      n_vout = 0; n_done = 0;
      send_frame(0, 1'b0);
      send_frame(0, 1'b1);
      drain();
      check("t3_windows", 256'(n_vout), 256'(2*WIN_PER_FRAME));
      check("t3_frame_done", 256'(n_done), 256'(2));

      // Reset at pixel (10,7), then a full frame
      for (int r = 0; r < IMG_H && !(r == 10); r++)
         for (int c = 0; c < IMG_W; c++) beat(r, c, pat_pix(r, c), 1'b1);
      for (int c = 0; c < 7; c++) beat(10, c, pat_pix(10, c), 1'b1);
      bus.valid_in = 1'b1;
      bus.pix_in   = pat_pix(10, 7);
      reset_pulse();
      n_vout = 0; n_done = 0;
      send_frame(0, 1'b1);
      drain();
      check("t4_windows", 256'(n_vout), 256'(WIN_PER_FRAME));
      check("t4_frame_done", 256'(n_done), 256'(1));

      // Random pixels with random gaps
      n_vout = 0; n_done = 0;
      send_frame(30, 1'b0);
      drain();
      check("t5_windows", 256'(n_vout), 256'(WIN_PER_FRAME));
      check("t5_frame_done", 256'(n_done), 256'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
